spy_uart_port: RTL and testbench
================================

Name: spy_uart_port

Overview:
- RS-232 debug bridge between a host serial line and the CPU's 16-bit "spy" register bus.
- Host sends single-byte commands (8N1 UART) to load a 16-bit data holding register and to read or write any of 32 spy registers (eadr).
- Read results and write acknowledgements are returned over rs232_txd.
- Sits in the top level beside the CPU core; runs on the system clock only.

Parameters:
- CLKS_PER_BIT, 434, sysclk cycles per UART bit (50 MHz / 115200).
- DB_CYCLES, 32, sysclk cycles dbread/dbwrite is held asserted. Must be at least two CPU clock periods; the CPU clock is sysclk/16.

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rs232_rxd  in  1  serial receive, idle high, asynchronous to sysclk.
- rs232_txd  out  1  serial transmit, idle high.
- spy_in  in  16  read data from CPU spy bus.
- spy_out  out  16  write data to CPU spy bus (= data holding register).
- dbread  out  1  spy read strobe.
- dbwrite  out  1  spy write strobe.
- eadr  out  5  spy register address.

Behaviour:
- Reset values: rs232_txd=1, dbread=0, dbwrite=0, eadr=0, spy_out=0, holding register=0, all FSMs idle, RX buffer empty.
- Reset mid-frame or mid-strobe aborts immediately to these values.

UART RX:
- rs232_rxd passes through a 2-flop synchronizer.
- Falling edge while idle starts a frame; start bit is rechecked at CLKS_PER_BIT/2, and a high sample there is a false start (return to idle).
- 8 data bits, LSB first, each sampled at mid-bit.
- Stop bit sampled mid-bit: 1 means the byte goes to a 1-entry buffer; 0 is a framing error and the byte is discarded.
- A byte completing while the buffer is full is dropped (overrun); the buffered byte is kept.

Command decode (the FSM accepts from the buffer only when idle, no strobe active and TX idle):
- 0x1n: hold[3:0]=n.
- 0x2n: hold[7:4]=n.
- 0x3n: hold[11:8]=n.
- 0x4n: hold[15:12]=n. Nibble loads send no response.
- 0x80–0x9F: read.
  - eadr=byte[4:0] is set, and dbread=1 from the next cycle for DB_CYCLES cycles.
  - spy_in is captured on the last asserted cycle, then dbread=0.
  - Then 4 response bytes are transmitted: 0x10|r[3:0], 0x20|r[7:4], 0x30|r[11:8], 0x40|r[15:12].
- 0xA0–0xBF: write.
  - eadr=byte[4:0]; spy_out=hold, stable before and throughout the strobe.
  - dbwrite=1 for DB_CYCLES cycles, then 0.
  - Then the command byte is echoed as the acknowledgement.
- All other bytes are ignored: no bus activity, no response.
- dbread and dbwrite are never asserted together. eadr and spy_out hold their last values after a strobe.
- Holding register is not modified by reads or writes, so repeated writes reuse it.

UART TX:
- 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each CLKS_PER_BIT cycles.
- Back-to-back response bytes are sent with no idle gap beyond the stop bit.
- rs232_txd is 1 whenever the transmitter is idle.
- Commands arriving during a transaction or response wait in the buffer and are processed in order after TX completes.

Test Plan (CLKS_PER_BIT=16, DB_CYCLES=8):
- Reset: hold reset 3 cycles → rs232_txd=1, dbread=dbwrite=0, eadr=0, spy_out=0; no TX activity for 1000 cycles.
- Write: send 0x14,0x23,0x32,0x41 then 0xA5 → spy_out=0x1234 before dbwrite rises; eadr=5; dbwrite high exactly 8 cycles; then TX byte 0xA5.
- Read: spy_in=0xBEEF, send 0x83 → eadr=3, dbread high exactly 8 cycles; TX bytes 0x1F,0x2E,0x3E,0x4B in order.
- Ignored and bad frames: send 0x55, then a frame with stop bit 0 carrying 0x80 → no strobes, no TX.
- Queued command: send 0x9F immediately followed by 0xA1 while the read response is transmitting → read of eadr=31 with 4 response bytes, then write to eadr=1 with echo 0xA1, never both strobes at once.
- Reset abort: assert reset in the middle of a dbwrite strobe → dbwrite=0 and rs232_txd=1 on the next cycle; the next command executes normally.

Source files
------------

// File: rtl/spy_uart_port.sv
// spy_uart_port
// RS-232 debug bridge between a host serial line and the CPU spy register bus.
// The host sends single-byte commands (8N1) that load a 16-bit holding
// register nibble by nibble, or read/write one of 32 spy registers. Read
// results and write acknowledgements are returned on rs232_txd.
//
// Ports:
//   sysclk     system clock, all logic on the rising edge
//   reset      synchronous active-high reset
//   rs232_rxd  serial receive (idle high, asynchronous to sysclk)
//   rs232_txd  serial transmit (idle high)
//   spy_in     read data from the CPU spy bus
//   spy_out    write data to the CPU spy bus (the holding register)
//   dbread     spy read strobe
//   dbwrite    spy write strobe
//   eadr       spy register address
module spy_uart_port #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DB_CYCLES    = 32
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rs232_rxd,
    output logic        rs232_txd,
    input  logic [15:0] spy_in,
    output logic [15:0] spy_out,
    output logic        dbread,
    output logic        dbwrite,
    output logic [4:0]  eadr
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {CMD_IDLE, CMD_SETUP, CMD_STROBE} cmd_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Receive side
    logic            rxd_meta, rxd_sync, rxd_prev;
    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_buf_valid;
    logic [7:0]      rx_buf_data;

    // Command side
    cmd_state_t      cmd_state;
    logic            cmd_is_write;
    logic [DW-1:0]   db_cnt;
    logic [15:0]     hold;
    logic            tx_go;
    logic [31:0]     tx_words;
    logic [2:0]      tx_count;
    logic            buf_pop;

    // Transmit side
    tx_state_t       tx_state;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_shift;
    logic [31:0]     tx_queue;
    logic [2:0]      tx_left;

    assign spy_out = hold;

    // A buffered command is taken only when the command FSM is idle (so no
    // strobe is active) and the transmitter is idle, including the cycle in
    // which a response has just been handed over but not yet started.
    assign buf_pop = (cmd_state == CMD_IDLE) && rx_buf_valid &&
                     (tx_state == TX_IDLE) && !tx_go;

    // Two-flop synchronizer for the asynchronous receive line, plus one more
    // stage so a falling edge can be detected on synchronized data. All
    // stages reset to the idle (high) level so reset never looks like a start.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rs232_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // Receiver: rechecks the start bit half a bit after the falling edge,
    // then samples every following bit at its middle. A good stop bit puts
    // the byte into the single-entry buffer unless it is still occupied, in
    // which case the new byte is lost and the buffered one survives.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_buf_valid <= 1'b0;
            rx_buf_data  <= '0;
        end else begin
            if (buf_pop) begin
                rx_buf_valid <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (rxd_prev && !rxd_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        if (!rxd_sync) begin
                            rx_state <= RX_DATA;
                            rx_bit   <= '0;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxd_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rxd_sync && !rx_buf_valid) begin
                            rx_buf_valid <= 1'b1;
                            rx_buf_data  <= rx_shift;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Command FSM: nibble loads complete in one cycle. Reads and writes
    // first drive eadr for one setup cycle, then hold the strobe for
    // DB_CYCLES cycles. On the last strobe cycle the response is handed to
    // the transmitter; for a read the bytes are built from spy_in as it is
    // seen during that last asserted cycle.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            cmd_state    <= CMD_IDLE;
            cmd_is_write <= 1'b0;
            db_cnt       <= '0;
            hold         <= '0;
            eadr         <= '0;
            dbread       <= 1'b0;
            dbwrite      <= 1'b0;
            tx_go        <= 1'b0;
            tx_words     <= '0;
            tx_count     <= '0;
        end else begin
            tx_go <= 1'b0;
            case (cmd_state)
                CMD_IDLE: begin
                    if (buf_pop) begin
                        case (rx_buf_data[7:4])
                            4'h1: hold[3:0]   <= rx_buf_data[3:0];
                            4'h2: hold[7:4]   <= rx_buf_data[3:0];
                            4'h3: hold[11:8]  <= rx_buf_data[3:0];
                            4'h4: hold[15:12] <= rx_buf_data[3:0];
                            4'h8, 4'h9: begin
                                eadr         <= rx_buf_data[4:0];
                                cmd_is_write <= 1'b0;
                                cmd_state    <= CMD_SETUP;
                            end
                            4'hA, 4'hB: begin
                                eadr         <= rx_buf_data[4:0];
                                cmd_is_write <= 1'b1;
                                cmd_state    <= CMD_SETUP;
                            end
                            default: ;
                        endcase
                    end
                end
                CMD_SETUP: begin
                    dbread    <= !cmd_is_write;
                    dbwrite   <= cmd_is_write;
                    db_cnt    <= '0;
                    cmd_state <= CMD_STROBE;
                end
                CMD_STROBE: begin
                    if (db_cnt == DB_LAST) begin
                        dbread    <= 1'b0;
                        dbwrite   <= 1'b0;
                        tx_go     <= 1'b1;
                        cmd_state <= CMD_IDLE;
                        if (cmd_is_write) begin
                            // The write command is 101a_aaaa, so the echo is
                            // rebuilt from the address it set.
                            tx_words <= {24'h0, 3'b101, eadr};
                            tx_count <= 3'd1;
                        end else begin
                            tx_words <= {4'h4, spy_in[15:12], 4'h3, spy_in[11:8],
                                         4'h2, spy_in[7:4],   4'h1, spy_in[3:0]};
                            tx_count <= 3'd4;
                        end
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: cmd_state <= CMD_IDLE;
            endcase
        end
    end

    // Transmitter: sends tx_count bytes from tx_words, lowest byte first.
    // At the end of a stop bit it goes straight into the next start bit if
    // bytes remain, so multi-byte responses have no idle gap.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            tx_queue  <= '0;
            tx_left   <= '0;
            rs232_txd <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    rs232_txd <= 1'b1;
                    if (tx_go) begin
                        tx_shift  <= tx_words[7:0];
                        tx_queue  <= {8'h0, tx_words[31:8]};
                        tx_left   <= tx_count - 3'd1;
                        tx_cnt    <= '0;
                        rs232_txd <= 1'b0;
                        tx_state  <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt    <= '0;
                        tx_bit    <= '0;
                        rs232_txd <= tx_shift[0];
                        tx_state  <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            rs232_txd <= 1'b1;
                            tx_state  <= TX_STOP;
                        end else begin
                            tx_bit    <= tx_bit + 1'b1;
                            rs232_txd <= tx_shift[1];
                            tx_shift  <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_left != 3'd0) begin
                            tx_shift  <= tx_queue[7:0];
                            tx_queue  <= {8'h0, tx_queue[31:8]};
                            tx_left   <= tx_left - 3'd1;
                            rs232_txd <= 1'b0;
                            tx_state  <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spy_uart_port.sv
// tb_spy_uart_port
// Self-checking bench for spy_uart_port. Commands are sent as serial frames;
// a reference model written from the command rules predicts the strobes and
// response bytes, and monitors decode what the design actually produces.
module tb_spy_uart_port;

    localparam int CPB = 16;
    localparam int DBC = 8;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        rs232_rxd = 1'b1;
    logic        rs232_txd;
    logic [15:0] spy_in;
    logic [15:0] spy_out;
    logic        dbread;
    logic        dbwrite;
    logic [4:0]  eadr;

    // CPU-side register file seen through the spy bus
    logic [15:0] spy_mem [32];
    assign spy_in = spy_mem[eadr];

    spy_uart_port #(
        .CLKS_PER_BIT(CPB),
        .DB_CYCLES(DBC)
    ) dut (
        .sysclk(sysclk),
        .reset(reset),
        .rs232_rxd(rs232_rxd),
        .rs232_txd(rs232_txd),
        .spy_in(spy_in),
        .spy_out(spy_out),
        .dbread(dbread),
        .dbwrite(dbwrite),
        .eadr(eadr)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        bit          is_write;
        logic [4:0]  addr;
        logic [15:0] data;
        int          len;
        bit          changed;
    } ev_t;

    int          n_compared = 0;
    int          n_mismatched = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [15:0] model_hold = 16'h0;
    logic [7:0]  got_tx[$];
    int          got_t[$];
    logic [7:0]  exp_tx[$];
    ev_t         got_ev[$];
    ev_t         exp_ev[$];

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_compared++;
        if (got !== expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // Free-running cycle counter used to timestamp received bytes.
    initial begin
        forever begin
            @(posedge sysclk);
            cyc++;
        end
    end

    // Serial receiver on the transmit line: samples each bit near its middle.
    initial begin
        logic [7:0] d;
        int         t0;
        forever begin
            @(negedge sysclk);
            if (mon_en && rs232_txd === 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge sysclk);
                checkOutput("tx_start_bit", {31'h0, rs232_txd}, 32'h0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge sysclk);
                    d[i] = rs232_txd;
                end
                repeat (CPB) @(negedge sysclk);
                checkOutput("tx_stop_bit", {31'h0, rs232_txd}, 32'h1);
                got_tx.push_back(d);
                got_t.push_back(t0);
            end
        end
    end

    // Strobe observer: records each strobe pulse with its address, the bus
    // data just before it rose, its length and whether write data moved.
    initial begin
        ev_t         cur;
        bit          in_strobe = 1'b0;
        logic [15:0] prev_spy = 16'h0;
        logic [15:0] start_spy = 16'h0;
        forever begin
            @(negedge sysclk);
            if (mon_en) begin
                if (dbread === 1'b1 || dbwrite === 1'b1) begin
                    checkOutput("strobe_exclusive", {31'h0, dbread & dbwrite}, 32'h0);
                    if (!in_strobe) begin
                        in_strobe   = 1'b1;
                        cur.is_write = dbwrite;
                        cur.addr    = eadr;
                        cur.data    = prev_spy;
                        cur.len     = 1;
                        cur.changed = 1'b0;
                        start_spy   = spy_out;
                    end else begin
                        cur.len++;
                        if (spy_out !== start_spy) cur.changed = 1'b1;
                    end
                end else if (in_strobe) begin
                    in_strobe = 1'b0;
                    got_ev.push_back(cur);
                end
                prev_spy = spy_out;
            end
        end
    end

    // Reference model of one accepted command byte.
    task automatic modelCommand(input logic [7:0] b);
        ev_t         ev;
        logic [15:0] r;
        ev.len     = DBC;
        ev.changed = 1'b0;
        ev.addr    = b[4:0];
        ev.data    = 16'h0;
        if (b >= 8'h10 && b <= 8'h1F) model_hold[3:0]   = b[3:0];
        else if (b >= 8'h20 && b <= 8'h2F) model_hold[7:4]   = b[3:0];
        else if (b >= 8'h30 && b <= 8'h3F) model_hold[11:8]  = b[3:0];
        else if (b >= 8'h40 && b <= 8'h4F) model_hold[15:12] = b[3:0];
        else if (b >= 8'h80 && b <= 8'h9F) begin
            ev.is_write = 1'b0;
            exp_ev.push_back(ev);
            r = spy_mem[b[4:0]];
            exp_tx.push_back(8'h10 + {4'h0, r[3:0]});
            exp_tx.push_back(8'h20 + {4'h0, r[7:4]});
            exp_tx.push_back(8'h30 + {4'h0, r[11:8]});
            exp_tx.push_back(8'h40 + {4'h0, r[15:12]});
        end else if (b >= 8'hA0 && b <= 8'hBF) begin
            ev.is_write = 1'b1;
            ev.data     = model_hold;
            exp_ev.push_back(ev);
            exp_tx.push_back(b);
        end
    endtask

    // Sends one 8N1 frame on rs232_rxd; stop_ok=0 produces a framing error.
    task automatic applyStimulus(input logic [7:0] b, input bit stop_ok);
        rs232_rxd = 1'b0;
        repeat (CPB) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            rs232_rxd = b[i];
            repeat (CPB) @(negedge sysclk);
        end
        rs232_rxd = stop_ok;
        repeat (CPB) @(negedge sysclk);
        rs232_rxd = 1'b1;
        if (stop_ok) modelCommand(b);
    endtask

    // Waits (bounded) until everything predicted has been observed and the
    // design is quiet, then lingers briefly to catch unexpected extras.
    task automatic settle();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge sysclk);
            if (got_tx.size() >= exp_tx.size() && got_ev.size() >= exp_ev.size() &&
                rs232_txd === 1'b1 && dbread === 1'b0 && dbwrite === 1'b0)
                done = 1'b1;
        end
        checkOutput("settle_done", {31'h0, done}, 32'h1);
        repeat (40) @(negedge sysclk);
    endtask

    task automatic clearQueues();
        got_tx.delete();
        got_t.delete();
        exp_tx.delete();
        got_ev.delete();
        exp_ev.delete();
    endtask

    // Compares observed bytes and strobes against the model, then empties both.
    task automatic checkQueues(input string tag);
        ev_t g;
        ev_t e;
        checkOutput({tag, "_tx_count"}, got_tx.size(), exp_tx.size());
        while (got_tx.size() > 0 && exp_tx.size() > 0)
            checkOutput({tag, "_tx_byte"}, {24'h0, got_tx.pop_front()}, {24'h0, exp_tx.pop_front()});
        checkOutput({tag, "_strobe_count"}, got_ev.size(), exp_ev.size());
        while (got_ev.size() > 0 && exp_ev.size() > 0) begin
            g = got_ev.pop_front();
            e = exp_ev.pop_front();
            checkOutput({tag, "_strobe_kind"}, {31'h0, g.is_write}, {31'h0, e.is_write});
            checkOutput({tag, "_strobe_eadr"}, {27'h0, g.addr}, {27'h0, e.addr});
            checkOutput({tag, "_strobe_len"}, g.len, e.len);
            if (e.is_write) begin
                checkOutput({tag, "_spy_out_before"}, {16'h0, g.data}, {16'h0, e.data});
                checkOutput({tag, "_spy_out_stable"}, {31'h0, g.changed}, 32'h0);
            end
        end
        clearQueues();
    endtask

    // Global time limit so the bench can never hang.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          low_cnt;
        int          kind;
        bit          saw;
        logic [7:0]  b;

        for (int i = 0; i < 32; i++) spy_mem[i] = 16'($urandom);

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        checkOutput("reset_txd", {31'h0, rs232_txd}, 32'h1);
        checkOutput("reset_dbread", {31'h0, dbread}, 32'h0);
        checkOutput("reset_dbwrite", {31'h0, dbwrite}, 32'h0);
        checkOutput("reset_eadr", {27'h0, eadr}, 32'h0);
        checkOutput("reset_spy_out", {16'h0, spy_out}, 32'h0);
        reset = 1'b0;
        mon_en = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge sysclk);
            if (rs232_txd !== 1'b1 || dbread !== 1'b0 || dbwrite !== 1'b0) low_cnt++;
        end
        checkOutput("idle_activity", low_cnt, 0);
        checkQueues("reset");

        // Nibble loads then a write
        applyStimulus(8'h14, 1'b1);
        applyStimulus(8'h23, 1'b1);
        applyStimulus(8'h32, 1'b1);
        applyStimulus(8'h41, 1'b1);
        settle();
        checkOutput("hold_loaded", {16'h0, spy_out}, 32'h1234);
        applyStimulus(8'hA5, 1'b1);
        settle();
        checkQueues("write");
        checkOutput("write_eadr_kept", {27'h0, eadr}, 32'h5);

        // Read with back-to-back response bytes
        spy_mem[3] = 16'hBEEF;
        applyStimulus(8'h83, 1'b1);
        settle();
        if (got_t.size() >= 4) begin
            for (int k = 1; k < 4; k++)
                checkOutput("read_byte_spacing", got_t[k] - got_t[k-1], 10 * CPB);
        end
        checkQueues("read");
        checkOutput("read_hold_untouched", {16'h0, spy_out}, 32'h1234);

        // Ignored byte and a framing error
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'h80, 1'b0);
        settle();
        checkQueues("ignored");
        checkOutput("ignored_hold", {16'h0, spy_out}, {16'h0, model_hold});

        // A write queued behind a read response
        applyStimulus(8'h9F, 1'b1);
        applyStimulus(8'hA1, 1'b1);
        settle();
        checkQueues("queued");

        // Randomized command mix
        for (int n = 0; n < 24; n++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       b = {4'($urandom_range(1, 4)), 4'($urandom)};
                1:       b = {3'b100, 5'($urandom)};
                2:       b = {3'b101, 5'($urandom)};
                default: b = 8'($urandom);
            endcase
            if (($urandom & 3) == 0) spy_mem[$urandom_range(0, 31)] = 16'($urandom);
            applyStimulus(b, 1'b1);
            settle();
            checkQueues("rand");
        end

        // Reset in the middle of a write strobe
        applyStimulus(8'h1C, 1'b1);
        applyStimulus(8'hA9, 1'b1);
        saw = 1'b0;
        for (int i = 0; i < 400 && !saw; i++) begin
            @(negedge sysclk);
            if (dbwrite === 1'b1) saw = 1'b1;
        end
        checkOutput("abort_strobe_seen", {31'h0, saw}, 32'h1);
        repeat (3) @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        checkOutput("abort_dbwrite", {31'h0, dbwrite}, 32'h0);
        checkOutput("abort_txd", {31'h0, rs232_txd}, 32'h1);
        checkOutput("abort_eadr", {27'h0, eadr}, 32'h0);
        checkOutput("abort_spy_out", {16'h0, spy_out}, 32'h0);
        reset = 1'b0;
        model_hold = 16'h0;
        repeat (5) @(negedge sysclk);
        clearQueues();
        applyStimulus(8'h15, 1'b1);
        applyStimulus(8'hA2, 1'b1);
        settle();
        checkQueues("after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
